sort_frame_loader: RTL and testbench
====================================

// Module: sort_frame_loader
// PURPOSE
//  Front-end sequencer for the min/max sort comparator. Collects NUM_INPUTS words from a serial
//  valid/ready stream and packs them into the comparator's DIN bus. Pulses the comparator's
//  restart, waits for its done flag, then returns the selected min/max on a valid/ready port.
//  Sits between the sample stream and the comparator, and owns the comparator's reset and mode.
// PARAMETERS
//  DATA_WIDTH      16  width of one data word
//  NUM_INPUTS      8   words per frame (>=2); counter width $clog2(NUM_INPUTS)
//  TIMEOUT_CYCLES  15  RUN-state watchdog limit, used only with SORT_TIMEOUT_EN
// PORTS
//  CLK        in   1                      clock, all logic on rising edge
//  RST_N      in   1                      asynchronous, active-low reset
//  IN_VALID   in   1                      input word valid
//  IN_READY   out  1                      loader accepts a word (high only in FILL)
//  IN_DATA    in   DATA_WIDTH             input word
//  FRAME_MODE in   1                      0=min, 1=max; sampled with the frame's first word
//  CMP_RST_N  out  1                      comparator reset, active-low, registered
//  CMP_MODE   out  1                      comparator MODE, held for the whole frame
//  CMP_DIN    out  DATA_WIDTH*NUM_INPUTS  packed frame; word k at [k*DATA_WIDTH +: DATA_WIDTH]
//  CMP_DOUT   in   DATA_WIDTH             comparator result
//  CMP_DONE   in   1                      comparator SORT_DONE
//  RES_VALID  out  1                      result valid
//  RES_READY  in   1                      result consumer ready
//  RES_DATA   out  DATA_WIDTH             captured min/max
//  BUSY       out  1                      high in LAUNCH, RUN and RESULT
//  ERR        out  1                      timeout flag (only with SORT_TIMEOUT_EN, else tied 0)
// BEHAVIOUR
//  Reset values: state=FILL, cnt=0; CMP_RST_N=0, CMP_MODE=0, CMP_DIN=0, RES_VALID=0,
//   RES_DATA=0, BUSY=0, ERR=0. IN_READY=(state==FILL), so it is 1 right after reset.
//  FILL: a word is accepted on each edge with IN_VALID&IN_READY. Word cnt goes to slot cnt.
//   When cnt==0, FRAME_MODE is also captured into CMP_MODE.
//   Accepting word NUM_INPUTS-1 moves to LAUNCH and sets cnt=0. CMP_RST_N stays 0.
//  LAUNCH (1 cycle): CMP_RST_N=0, CMP_DIN complete and stable. Next state is RUN.
//  RUN: CMP_RST_N=1, so the comparator loads DIN on the 1st edge and sorts on the 2nd.
//   When CMP_DONE is sampled 1: RES_DATA<=CMP_DOUT, RES_VALID<=1, CMP_RST_N<=0, go to RESULT.
//  RESULT: RES_VALID and RES_DATA hold stable until the RES_READY handshake.
//   On the handshake edge: RES_VALID<=0 and go to FILL. The next word is accepted 1 cycle later.
//  Latency: last word accepted at edge t -> RES_VALID=1 after edge t+4 (comparator 2-cycle sort).
//  CMP_DIN and CMP_MODE change only in FILL. They never change during LAUNCH, RUN or RESULT.
//  IN_VALID outside FILL: ignored, because IN_READY=0. No word is lost or duplicated.
//  CMP_DONE outside RUN: ignored.
//  RES_READY high before RES_VALID: has no effect. The handshake requires both high on the same edge.
//  Reset mid-frame or mid-sort: partial frame discarded, all registers return to reset values,
//   comparator held in reset.
//  Equal words: result equals that value. Unsigned comparison is done entirely in the comparator.
// CONFIGURATION
//  SORT_TIMEOUT_EN defined: RUN counts cycles. If CMP_DONE has not been seen after TIMEOUT_CYCLES
//   cycles, go to RESULT with RES_DATA=0, ERR=1, CMP_RST_N=0.
//   ERR clears on the RES handshake. The counter clears on entry to RUN.
//  SORT_TIMEOUT_EN undefined: no counter, RUN waits indefinitely, ERR tied 0.
// TESTING
//  1. Frame 45,3,29,88,7,100,12,60 with FRAME_MODE=0 -> RES_DATA=3.
//     Same frame with FRAME_MODE=1 -> RES_DATA=100. ERR=0 in both.
//  2. RES_READY low for 10 cycles after RES_VALID -> RES_VALID/RES_DATA stable, IN_READY=0.
//     After release the next frame is accepted.
//  3. Random IN_VALID gaps -> CMP_DIN[15:0]=1st word, [127:112]=8th word.
//     Result is identical to the gap-free run, and CMP_DIN is stable from LAUNCH to RESULT.
//  4. RST_N asserted after 5 of 8 words -> IN_READY=1 and CMP_RST_N=0.
//     A new full frame 9,8,7,6,5,4,3,2 with mode 0 -> RES_DATA=2.
//  5. All words 0xFFFF -> 0xFFFF in both modes.
//     Frame containing 0x0000 and 0xFFFF -> min 0x0000, max 0xFFFF.
//  6. With SORT_TIMEOUT_EN and CMP_DONE stuck at 0 -> RES_VALID=1, ERR=1, RES_DATA=0
//     after TIMEOUT_CYCLES cycles in RUN.

Source files
------------

// File: rtl/sort_frame_loader_if.sv
// Bundle of stream, comparator and result signals around sort_frame_loader.
// slave = loader side, master = environment side.
interface sort_frame_loader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_INPUTS = 8
);
  logic                             IN_VALID;
  logic                             IN_READY;
  logic [DATA_WIDTH-1:0]            IN_DATA;
  logic                             FRAME_MODE;
  logic                             CMP_RST_N;
  logic                             CMP_MODE;
  logic [DATA_WIDTH*NUM_INPUTS-1:0] CMP_DIN;
  logic [DATA_WIDTH-1:0]            CMP_DOUT;
  logic                             CMP_DONE;
  logic                             RES_VALID;
  logic                             RES_READY;
  logic [DATA_WIDTH-1:0]            RES_DATA;
  logic                             BUSY;
  logic                             ERR;

  modport slave (
    input  IN_VALID, IN_DATA, FRAME_MODE, CMP_DOUT, CMP_DONE, RES_READY,
    output IN_READY, CMP_RST_N, CMP_MODE, CMP_DIN, RES_VALID, RES_DATA, BUSY, ERR
  );

  modport master (
    output IN_VALID, IN_DATA, FRAME_MODE, CMP_DOUT, CMP_DONE, RES_READY,
    input  IN_READY, CMP_RST_N, CMP_MODE, CMP_DIN, RES_VALID, RES_DATA, BUSY, ERR
  );
endinterface

// File: rtl/sort_frame_loader.sv
// Frame loader/sequencer for the min/max sort comparator.
// Optional RUN watchdog enabled by defining SORT_TIMEOUT_EN.
module sort_frame_loader #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_INPUTS     = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                CLK,
  input  logic                RST_N,
  sort_frame_loader_if.slave  bus
);
  localparam int              CW       = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
  localparam logic [CW-1:0]   LAST_IDX = CW'(NUM_INPUTS - 1);

  typedef enum logic [1:0] {ST_FILL, ST_LAUNCH, ST_RUN, ST_RESULT} state_t;

  state_t                           r_state, w_next_state;
  logic [CW-1:0]                    r_cnt;
  logic                             r_cmp_rst_n;
  logic                             r_cmp_mode;
  logic [DATA_WIDTH*NUM_INPUTS-1:0] r_cmp_din;
  logic                             r_res_valid;
  logic [DATA_WIDTH-1:0]            r_res_data;
  logic                             w_in_fire;

  if (NUM_INPUTS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("sort_frame_loader: NUM_INPUTS must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  assign w_in_fire = bus.IN_VALID && (r_state == ST_FILL);

`ifdef SORT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_tmo_cnt;
  logic          r_err;
  logic          w_tmo_hit;

  assign w_tmo_hit = (r_state == ST_RUN) && (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (r_state == ST_LAUNCH)
        r_tmo_cnt <= '0;
      else if (r_state == ST_RUN)
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (w_tmo_hit && !bus.CMP_DONE)
        r_err <= 1'b1;
      else if (r_state == ST_RESULT && bus.RES_READY)
        r_err <= 1'b0;
    end
  end

  assign bus.ERR = r_err;
`else
  assign bus.ERR = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= ST_FILL;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_FILL:   if (w_in_fire && r_cnt == LAST_IDX) w_next_state = ST_LAUNCH;
      ST_LAUNCH: w_next_state = ST_RUN;
`ifdef SORT_TIMEOUT_EN
      ST_RUN:    if (bus.CMP_DONE || w_tmo_hit) w_next_state = ST_RESULT;
`else
      ST_RUN:    if (bus.CMP_DONE) w_next_state = ST_RESULT;
`endif
      ST_RESULT: if (bus.RES_READY) w_next_state = ST_FILL;
      default:   w_next_state = ST_FILL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt       <= '0;
      r_cmp_rst_n <= 1'b0;
      r_cmp_mode  <= 1'b0;
      r_cmp_din   <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      // Comparator runs only while RUN is the upcoming state.
      r_cmp_rst_n <= (w_next_state == ST_RUN);
      unique case (r_state)
        ST_FILL: begin
          if (w_in_fire) begin
            for (int unsigned k = 0; k < NUM_INPUTS; k++) begin
              if (r_cnt == CW'(k))
                r_cmp_din[k*DATA_WIDTH +: DATA_WIDTH] <= bus.IN_DATA;
            end
            if (r_cnt == '0)
              r_cmp_mode <= bus.FRAME_MODE;
            r_cnt <= (r_cnt == LAST_IDX) ? '0 : r_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.CMP_DONE) begin
            r_res_data  <= bus.CMP_DOUT;
            r_res_valid <= 1'b1;
          end
`ifdef SORT_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_res_data  <= '0;
            r_res_valid <= 1'b1;
          end
`endif
        end
        ST_RESULT: begin
          if (bus.RES_READY)
            r_res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.IN_READY  = (r_state == ST_FILL);
  assign bus.BUSY      = (r_state != ST_FILL);
  assign bus.CMP_RST_N = r_cmp_rst_n;
  assign bus.CMP_MODE  = r_cmp_mode;
  assign bus.CMP_DIN   = r_cmp_din;
  assign bus.RES_VALID = r_res_valid;
  assign bus.RES_DATA  = r_res_data;
endmodule

// File: tb/tb_sort_frame_loader.sv
// Scoreboard bench for sort_frame_loader with a behavioural 2-cycle comparator.
module tb_sort_frame_loader;
  localparam int DW  = 16;
  localparam int N   = 8;
  localparam int TMO = 15;
  localparam int BW  = DW * N;

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  sort_frame_loader_if #(.DATA_WIDTH(DW), .NUM_INPUTS(N)) bus ();

  sort_frame_loader #(.DATA_WIDTH(DW), .NUM_INPUTS(N), .TIMEOUT_CYCLES(TMO)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  typedef struct {
    logic [DW-1:0] res;
    logic [BW-1:0] din;
    logic          mode;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            cyc   = 0;
  int            t_last = 0;
  logic [DW-1:0] frame [N];
  logic          stuck = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pick(input logic [BW-1:0] d, input logic mx);
    logic [DW-1:0] r;
    r = d[DW-1:0];
    for (int i = 1; i < N; i++) begin
      if (mx ? (d[i*DW +: DW] > r) : (d[i*DW +: DW] < r)) r = d[i*DW +: DW];
    end
    return r;
  endfunction

  // Comparator: loads DIN on the first enabled edge, result+done on the second.
  int            m_phase = 0;
  logic [BW-1:0] m_din;
  logic          m_mode;
  always @(posedge CLK) begin
    if (bus.CMP_RST_N !== 1'b1) begin
      m_phase      <= 0;
      bus.CMP_DONE <= 1'b0;
      bus.CMP_DOUT <= '0;
    end else if (m_phase == 0) begin
      m_din   <= bus.CMP_DIN;
      m_mode  <= bus.CMP_MODE;
      m_phase <= 1;
    end else if (m_phase == 1 && !stuck) begin
      bus.CMP_DOUT <= pick(m_din, m_mode);
      bus.CMP_DONE <= 1'b1;
      m_phase      <= 2;
    end
  end

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Enter and leave at a negedge; FRAME_MODE is inverted after word 0 to
  // show it is sampled with the first word only.
  task automatic send(input int nw, input logic mode, input int maxgap);
    logic [BW-1:0] d;
    int k;
    exp_t e;
    d = '0;
    for (int i = 0; i < nw; i++) begin
      bus.IN_VALID = 1'b0;
      repeat ((maxgap > 0) ? $urandom_range(0, maxgap) : 0) @(negedge CLK);
      bus.IN_VALID   = 1'b1;
      bus.IN_DATA    = frame[i];
      bus.FRAME_MODE = (i == 0) ? mode : ~mode;
      k = 0;
      while (!bus.IN_READY && k < 100) begin
        @(negedge CLK);
        k++;
      end
      if (!bus.IN_READY) begin
        check("in_ready_wait", 0, 1);
        bus.IN_VALID = 1'b0;
        return;
      end
      @(posedge CLK);
      @(negedge CLK);
      d[i*DW +: DW] = frame[i];
    end
    bus.IN_VALID = 1'b0;
    t_last = cyc;
    if (nw == N) begin
      e.din  = d;
      e.mode = mode;
      e.res  = stuck ? '0 : pick(d, mode);
      e.err  = stuck;
      sb.push_back(e);
    end
  endtask

  task automatic get_res(input int hold, input int exp_lat);
    int k;
    exp_t e;
    k = 0;
    while (!bus.RES_VALID && k < 200) begin
      if (bus.BUSY && sb.size() > 0) check("din_stable", bus.CMP_DIN, sb[$].din);
      @(negedge CLK);
      k++;
    end
    if (!bus.RES_VALID) begin
      check("res_valid_wait", 0, 1);
      return;
    end
    if (sb.size() == 0) begin
      check("unexpected_result", 1, 0);
      return;
    end
    e = sb.pop_front();
    check("latency",   BW'(cyc - t_last), BW'(exp_lat));
    check("res_data",  BW'(bus.RES_DATA), BW'(e.res));
    check("err",       BW'(bus.ERR), BW'(e.err));
    check("cmp_din",   bus.CMP_DIN, e.din);
    check("cmp_mode",  BW'(bus.CMP_MODE), BW'(e.mode));
    check("busy",      BW'(bus.BUSY), 1);
    check("in_ready",  BW'(bus.IN_READY), 0);
    repeat (hold) begin
      @(negedge CLK);
      check("hold_valid", BW'(bus.RES_VALID), 1);
      check("hold_data",  BW'(bus.RES_DATA), BW'(e.res));
      check("hold_ready", BW'(bus.IN_READY), 0);
    end
    bus.RES_READY = 1'b1;
    @(negedge CLK);
    bus.RES_READY = 1'b0;
    check("post_valid", BW'(bus.RES_VALID), 0);
    check("post_ready", BW'(bus.IN_READY), 1);
    check("post_err",   BW'(bus.ERR), 0);
    check("post_busy",  BW'(bus.BUSY), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    bus.IN_VALID   = 1'b0;
    bus.IN_DATA    = '0;
    bus.FRAME_MODE = 1'b0;
    bus.RES_READY  = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_in_ready",  BW'(bus.IN_READY), 1);
    check("rst_cmp_rst_n", BW'(bus.CMP_RST_N), 0);
    check("rst_cmp_mode",  BW'(bus.CMP_MODE), 0);
    check("rst_cmp_din",   bus.CMP_DIN, '0);
    check("rst_res_valid", BW'(bus.RES_VALID), 0);
    check("rst_res_data",  BW'(bus.RES_DATA), 0);
    check("rst_busy",      BW'(bus.BUSY), 0);
    check("rst_err",       BW'(bus.ERR), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    frame = '{16'd45, 16'd3, 16'd29, 16'd88, 16'd7, 16'd100, 16'd12, 16'd60};
    send(N, 1'b0, 0);  get_res(0, 4);
    check("min_ref", BW'(pick({16'd60, 16'd12, 16'd100, 16'd7, 16'd88, 16'd29, 16'd3, 16'd45}, 1'b0)), 3);
    send(N, 1'b1, 0);  get_res(0, 4);

    // Back-pressured result, then gapped input on the following frame.
    send(N, 1'b0, 0);  get_res(10, 4);
    send(N, 1'b1, 3);  get_res(0, 4);
    send(N, 1'b0, 3);  get_res(0, 4);

    frame = '{16'd9, 16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2};
    send(5, 1'b0, 0);
    RST_N = 1'b0;
    @(negedge CLK);
    check("mid_rst_in_ready",  BW'(bus.IN_READY), 1);
    check("mid_rst_cmp_rst_n", BW'(bus.CMP_RST_N), 0);
    check("mid_rst_cmp_din",   bus.CMP_DIN, '0);
    RST_N = 1'b1;
    @(negedge CLK);
    send(N, 1'b0, 0);  get_res(0, 4);

    frame = '{default: 16'hFFFF};
    send(N, 1'b0, 0);  get_res(0, 4);
    send(N, 1'b1, 0);  get_res(0, 4);
    frame = '{16'h1234, 16'hFFFF, 16'h0001, 16'h0000, 16'h8000, 16'h7FFF, 16'hFFFE, 16'h00FF};
    send(N, 1'b0, 0);  get_res(0, 4);
    send(N, 1'b1, 2);  get_res(0, 4);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < N; i++) frame[i] = DW'($urandom);
      send(N, f[0], 2);
      get_res(f, 4);
    end

`ifdef SORT_TIMEOUT_EN
    stuck = 1'b1;
    frame = '{16'd45, 16'd3, 16'd29, 16'd88, 16'd7, 16'd100, 16'd12, 16'd60};
    send(N, 1'b1, 0);  get_res(2, TMO + 1);
    stuck = 1'b0;
    send(N, 1'b1, 0);  get_res(0, 4);
`endif

    check("sb_empty", BW'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
